// File: rtl/tx_ethernet_if.sv
// rtl/tx_ethernet_if.sv - frame request, status and payload stream bundle for tx_ethernet
//
// Signals:
//   tx_start          frame request, single-cycle pulse (master -> slave)
//   tx_mac_dst        destination MAC, sampled on accept (master -> slave)
//   tx_len_type       length/type field, sampled on accept (master -> slave)
//   tx_busy           accept through end of interframe gap (slave -> master)
//   tx_done           one-cycle pulse after a good frame's gap (slave -> master)
//   tx_err            one-cycle pulse when a frame is aborted (slave -> master)
//   tx_payload        payload octet (master -> slave)
//   tx_payload_valid  payload octet valid (master -> slave)
//   tx_payload_last   final payload octet marker (master -> slave)
//   tx_payload_ready  transmitter can take a payload octet (slave -> master)
// Modports: master = frame source, slave = transmitter.

interface tx_ethernet_if #(
    parameter int OCT = 8
);
    logic           tx_start;
    logic [47:0]    tx_mac_dst;
    logic [15:0]    tx_len_type;
    logic           tx_busy;
    logic           tx_done;
    logic           tx_err;
    logic [OCT-1:0] tx_payload;
    logic           tx_payload_valid;
    logic           tx_payload_last;
    logic           tx_payload_ready;

    modport master (
        output tx_start,
        output tx_mac_dst,
        output tx_len_type,
        input  tx_busy,
        input  tx_done,
        input  tx_err,
        output tx_payload,
        output tx_payload_valid,
        output tx_payload_last,
        input  tx_payload_ready
    );

    modport slave (
        input  tx_start,
        input  tx_mac_dst,
        input  tx_len_type,
        output tx_busy,
        output tx_done,
        output tx_err,
        input  tx_payload,
        input  tx_payload_valid,
        input  tx_payload_last,
        output tx_payload_ready
    );
endinterface

// File: rtl/tx_ethernet.sv
// rtl/tx_ethernet.sv - GMII Ethernet frame transmitter
//
// Serialises preamble, SFD, destination MAC, source MAC, length/type, payload,
// zero padding, optional FCS, then holds the line idle for the interframe gap.
// Optional feature: define TX_FCS_EN to append a CRC-32 FCS (4 octets, low octet
// first) computed over destination MAC through pad.
//
// Ports:
//   RX_CLK    clock, also forwarded as the GMII transmit clock
//   rst       synchronous, active-high reset
//   mac_addr  local MAC, sent as the source address
//   bus       tx_ethernet_if.slave: request, status and payload stream
//   TXD       GMII data, registered
//   TX_EN     GMII enable, registered
//   TX_ER     GMII error, registered

module tx_ethernet #(
    parameter int           OCT         = 8,
    parameter logic [OCT-1:0] PRE       = 8'b10101010,
    parameter logic [OCT-1:0] SFD       = 8'b10101011,
    parameter int           PRE_LEN     = 7,
    parameter int           MIN_PAYLOAD = 46,
    parameter int           MAX_PAYLOAD = 1500,
    parameter int           IFG_LEN     = 12
) (
    input  logic           RX_CLK,
    input  logic           rst,
    input  logic [47:0]    mac_addr,
    tx_ethernet_if.slave   bus,
    output logic [OCT-1:0] TXD,
    output logic           TX_EN,
    output logic           TX_ER
);

    typedef enum logic [3:0] {
        TX_IDLE,
        TX_PRE,
        TX_SFD,
        TX_MAC_DST,
        TX_MAC_SRC,
        TX_LEN_TYPE,
        TX_DATA,
        TX_PAD,
`ifdef TX_FCS_EN
        TX_FCS,
`endif
        TX_IFG
    } state_t;

    // Where the frame goes once payload (and pad) is complete.
`ifdef TX_FCS_EN
    localparam state_t AFTER_PAYLOAD = TX_FCS;
`else
    localparam state_t AFTER_PAYLOAD = TX_IFG;
`endif

    localparam logic [7:0]  PRE_LAST = 8'(PRE_LEN - 1);
    // IFG state lasts IFG_LEN+1 cycles: the first carries the final frame octet
    // (or the TX_ER octet) out of the output register, the rest are idle.
    localparam logic [7:0]  IFG_LAST = 8'(IFG_LEN);
    localparam logic [10:0] MIN_P    = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_P    = 11'(MAX_PAYLOAD);

    state_t         state_q, state_n;
    logic [7:0]     cnt_q, cnt_n;
    logic [10:0]    pay_q, pay_n;
    logic [10:0]    pay_inc;
    logic [47:0]    sh_q, sh_n;
    logic [15:0]    lt_q, lt_n;
    logic           busy_q, busy_n;
    logic           done_q, done_n;
    logic           err_q, err_n;
    logic           abort_q, abort_n;
    logic [OCT-1:0] txd_n;
    logic           en_n, er_n;

`ifdef TX_FCS_EN
    logic [31:0]    crc_q, crc_n;

    // Reflected CRC-32 (poly 0x04C11DB7), one octet, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction
`endif

    assign pay_inc               = pay_q + 11'd1;
    assign bus.tx_payload_ready  = (state_q == TX_DATA);
    assign bus.tx_busy           = busy_q;
    assign bus.tx_done           = done_q;
    assign bus.tx_err            = err_q;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        pay_n   = pay_q;
        sh_n    = sh_q;
        lt_n    = lt_q;
        busy_n  = busy_q;
        abort_n = abort_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        txd_n   = '0;
        en_n    = 1'b0;
        er_n    = 1'b0;
`ifdef TX_FCS_EN
        crc_n   = crc_q;
`endif

        case (state_q)
            TX_IDLE: begin
                if (bus.tx_start) begin
                    state_n = TX_PRE;
                    cnt_n   = '0;
                    pay_n   = '0;
                    // Destination MAC parks in the shift register until TX_MAC_DST.
                    sh_n    = bus.tx_mac_dst;
                    lt_n    = bus.tx_len_type;
                    busy_n  = 1'b1;
                    abort_n = 1'b0;
`ifdef TX_FCS_EN
                    crc_n   = 32'hFFFFFFFF;
`endif
                end
            end

            TX_PRE: begin
                en_n  = 1'b1;
                txd_n = PRE;
                if (cnt_q == PRE_LAST) begin
                    state_n = TX_SFD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end

            TX_SFD: begin
                en_n    = 1'b1;
                txd_n   = SFD;
                state_n = TX_MAC_DST;
                cnt_n   = '0;
            end

            // Address and length/type fields all go out MSB octet first by
            // shifting the 48-bit register left one octet per cycle.
            TX_MAC_DST: begin
                en_n  = 1'b1;
                txd_n = sh_q[47:40];
                sh_n  = {sh_q[39:0], 8'h00};
                if (cnt_q == 8'd5) begin
                    state_n = TX_MAC_SRC;
                    cnt_n   = '0;
                    sh_n    = mac_addr;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end

            TX_MAC_SRC: begin
                en_n  = 1'b1;
                txd_n = sh_q[47:40];
                sh_n  = {sh_q[39:0], 8'h00};
                if (cnt_q == 8'd5) begin
                    state_n = TX_LEN_TYPE;
                    cnt_n   = '0;
                    sh_n    = {lt_q, 32'h0};
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end

            TX_LEN_TYPE: begin
                en_n  = 1'b1;
                txd_n = sh_q[47:40];
                sh_n  = {sh_q[39:0], 8'h00};
                if (cnt_q == 8'd1) begin
                    state_n = TX_DATA;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end

            TX_DATA: begin
                en_n = 1'b1;
                // Underflow (no octet offered) or an octet beyond MAX_PAYLOAD:
                // emit one TX_ER cycle and abandon the frame.
                if (!bus.tx_payload_valid || pay_q == MAX_P) begin
                    er_n    = 1'b1;
                    txd_n   = '0;
                    err_n   = 1'b1;
                    abort_n = 1'b1;
                    state_n = TX_IFG;
                    cnt_n   = '0;
                end else begin
                    txd_n = bus.tx_payload;
                    pay_n = pay_inc;
                    if (bus.tx_payload_last) begin
                        cnt_n   = '0;
                        state_n = (pay_inc < MIN_P) ? TX_PAD : AFTER_PAYLOAD;
                    end
                end
            end

            TX_PAD: begin
                en_n  = 1'b1;
                txd_n = '0;
                pay_n = pay_inc;
                if (pay_inc == MIN_P) begin
                    state_n = AFTER_PAYLOAD;
                    cnt_n   = '0;
                end
            end

`ifdef TX_FCS_EN
            // Final complement applied octet by octet; the register is shifted
            // right so the next FCS octet is always in the low byte.
            TX_FCS: begin
                en_n  = 1'b1;
                txd_n = ~crc_q[7:0];
                crc_n = {8'h00, crc_q[31:8]};
                if (cnt_q == 8'd3) begin
                    state_n = TX_IFG;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end
`endif

            TX_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_n = TX_IDLE;
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                    done_n  = !abort_q;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end

            default: begin
                state_n = TX_IDLE;
            end
        endcase

`ifdef TX_FCS_EN
        // Every good octet from destination MAC through pad feeds the CRC.
        if (en_n && !er_n && (state_q == TX_MAC_DST || state_q == TX_MAC_SRC ||
                              state_q == TX_LEN_TYPE || state_q == TX_DATA ||
                              state_q == TX_PAD)) begin
            crc_n = crc_byte(crc_q, txd_n);
        end
`endif
    end

    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            pay_q   <= '0;
            sh_q    <= '0;
            lt_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            TXD     <= '0;
            TX_EN   <= 1'b0;
            TX_ER   <= 1'b0;
`ifdef TX_FCS_EN
            crc_q   <= '0;
`endif
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            pay_q   <= pay_n;
            sh_q    <= sh_n;
            lt_q    <= lt_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            err_q   <= err_n;
            abort_q <= abort_n;
            TXD     <= txd_n;
            TX_EN   <= en_n;
            TX_ER   <= er_n;
`ifdef TX_FCS_EN
            crc_q   <= crc_n;
`endif
        end
    end

endmodule

// File: tb/tb_tx_ethernet.sv
// tb/tb_tx_ethernet.sv - self-checking bench for tx_ethernet

`timescale 1ns/1ps

module tb_tx_ethernet;
    localparam int IFG_LEN = 12;

    logic        RX_CLK = 1'b0;
    logic        rst;
    logic [47:0] mac_addr;
    logic [7:0]  TXD;
    logic        TX_EN;
    logic        TX_ER;

    tx_ethernet_if ifc ();

    tx_ethernet dut (
        .RX_CLK   (RX_CLK),
        .rst      (rst),
        .mac_addr (mac_addr),
        .bus      (ifc),
        .TXD      (TXD),
        .TX_EN    (TX_EN),
        .TX_ER    (TX_ER)
    );

    always #5 RX_CLK = ~RX_CLK;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [8:0]  exp_q[$];
    logic [7:0]  pl[$];
    logic [31:0] crc_m;
    bit          mon_en = 1'b0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          low_run = 0;
    int          last_gap = -1;
    int          d0, e0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference CRC-32 (reflected, poly 0xEDB88320).
    function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    task automatic push(input logic [7:0] b, input bit in_crc, input bit er);
        exp_q.push_back({er, b});
        if (in_crc) crc_m = crc_ref(crc_m, b);
    endtask

    task automatic push_hdr(input logic [47:0] dst, input logic [15:0] lt);
        crc_m = 32'hFFFFFFFF;
        repeat (7) push(8'hAA, 1'b0, 1'b0);
        push(8'hAB, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) push(dst[8*(5-k) +: 8], 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) push(mac_addr[8*(5-k) +: 8], 1'b1, 1'b0);
        push(lt[15:8], 1'b1, 1'b0);
        push(lt[7:0], 1'b1, 1'b0);
    endtask

    task automatic push_payload(input int n);
        for (int i = 0; i < n; i++) push(pl[i], 1'b1, 1'b0);
    endtask

    task automatic push_tail(input int n);
        logic [31:0] f;
        for (int i = n; i < 46; i++) push(8'h00, 1'b1, 1'b0);
`ifdef TX_FCS_EN
        f = ~crc_m;
        for (int k = 0; k < 4; k++) push(f[8*k +: 8], 1'b0, 1'b0);
`else
        f = crc_m;
`endif
    endtask

    task automatic start_frame(input logic [47:0] dst, input logic [15:0] lt);
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge RX_CLK);
        ifc.tx_start    = 1'b1;
        ifc.tx_mac_dst  = dst;
        ifc.tx_len_type = lt;
        @(negedge RX_CLK);
        ifc.tx_start    = 1'b0;
        // Scramble the request fields: the frame must use the latched copies.
        ifc.tx_mac_dst  = 48'hDEAD_BEEF_0BAD;
        ifc.tx_len_type = 16'hFFFF;
        check("busy_on_accept", ifc.tx_busy, 1);
        check("en_low_after_accept", TX_EN, 0);
    endtask

    task automatic send(input int n, input bit mark_last);
        int i = 0;
        int t = 0;
        while (i < n && t < 4000) begin
            @(negedge RX_CLK);
            t++;
            ifc.tx_payload_valid = 1'b1;
            ifc.tx_payload       = pl[i];
            ifc.tx_payload_last  = mark_last && (i == n - 1);
            if (ifc.tx_payload_ready) i++;
        end
        @(negedge RX_CLK);
        ifc.tx_payload_valid = 1'b0;
        ifc.tx_payload_last  = 1'b0;
        check("payload_consumed", i, n);
    endtask

    task automatic wait_idle(input int exp_done, input int exp_err);
        int t = 0;
        while (ifc.tx_busy && t < 5000) begin
            @(negedge RX_CLK);
            t++;
        end
        check("busy_cleared", ifc.tx_busy, 0);
        repeat (2) @(negedge RX_CLK);
        check("sb_drained", exp_q.size(), 0);
        check("done_pulses", done_cnt - d0, exp_done);
        check("err_pulses", err_cnt - e0, exp_err);
        if (exp_done != 0) check("ifg_idle_cycles", last_gap, IFG_LEN);
    endtask

    // Monitor: pops the scoreboard on every TX_EN cycle, tallies status pulses.
    always @(negedge RX_CLK) begin
        if (ifc.tx_done) begin
            done_cnt++;
            last_gap = low_run;
        end
        if (ifc.tx_err) err_cnt++;
        low_run = TX_EN ? 0 : low_run + 1;
        if (mon_en && !rst && TX_EN) begin
            check("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("octet", {TX_ER, TXD}, exp_q.pop_front());
        end
    end

    initial begin
        rst                  = 1'b1;
        mac_addr             = 48'hAABBCCDDEEFF;
        ifc.tx_start         = 1'b0;
        ifc.tx_mac_dst       = '0;
        ifc.tx_len_type      = '0;
        ifc.tx_payload       = '0;
        ifc.tx_payload_valid = 1'b0;
        ifc.tx_payload_last  = 1'b0;
        repeat (3) @(negedge RX_CLK);

        check("rst_txd", TXD, 0);
        check("rst_tx_en", TX_EN, 0);
        check("rst_tx_er", TX_ER, 0);
        check("rst_busy", ifc.tx_busy, 0);
        check("rst_done", ifc.tx_done, 0);
        check("rst_err", ifc.tx_err, 0);
        check("rst_ready", ifc.tx_payload_ready, 0);

        rst = 1'b0;
        @(negedge RX_CLK);
        mon_en = 1'b1;

        // Minimal frame: 46 octets 0x00..0x2D, no padding.
        pl.delete();
        for (int i = 0; i < 46; i++) pl.push_back(8'(i));
        push_hdr(48'h112233445566, 16'h0800);
        push_payload(46);
        push_tail(46);
        start_frame(48'h112233445566, 16'h0800);
        send(46, 1'b1);
        wait_idle(1, 0);

        // Padding, with a stray tx_start while busy.
        pl.delete();
        pl.push_back(8'h01);
        pl.push_back(8'h02);
        pl.push_back(8'h03);
        push_hdr(48'h0A0B0C0D0E0F, 16'h0003);
        push_payload(3);
        push_tail(3);
        start_frame(48'h0A0B0C0D0E0F, 16'h0003);
        fork
            send(3, 1'b1);
            begin
                repeat (10) @(negedge RX_CLK);
                ifc.tx_start   = 1'b1;
                ifc.tx_mac_dst = 48'h0;
                @(negedge RX_CLK);
                ifc.tx_start   = 1'b0;
            end
        join
        wait_idle(1, 0);

        // Underflow after 10 payload octets.
        pl.delete();
        for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
        push_hdr(48'h665544332211, 16'h86DD);
        push_payload(10);
        push(8'h00, 1'b0, 1'b1);
        start_frame(48'h665544332211, 16'h86DD);
        send(10, 1'b0);
        wait_idle(0, 1);

        // Reset during TX_MAC_SRC.
        mon_en = 1'b0;
        start_frame(48'h010203040506, 16'h0800);
        repeat (16) @(negedge RX_CLK);
        check("en_before_rst", TX_EN, 1);
        rst = 1'b1;
        @(negedge RX_CLK);
        check("rst_mid_tx_en", TX_EN, 0);
        check("rst_mid_busy", ifc.tx_busy, 0);
        repeat (3) @(negedge RX_CLK);
        rst = 1'b0;
        repeat (3) @(negedge RX_CLK);
        check("rst_mid_no_done", done_cnt - d0, 0);
        check("rst_mid_no_err", err_cnt - e0, 0);
        exp_q.delete();
        mon_en = 1'b1;

        // Maximum payload: 1500 octets completes.
        pl.delete();
        for (int i = 0; i < 1501; i++) pl.push_back(8'($urandom));
        push_hdr(48'hFFFFFFFFFFFF, 16'h05DC);
        push_payload(1500);
        push_tail(1500);
        start_frame(48'hFFFFFFFFFFFF, 16'h05DC);
        send(1500, 1'b1);
        wait_idle(1, 0);

        // Overflow: the 1501st octet aborts.
        push_hdr(48'h0123456789AB, 16'h0800);
        push_payload(1500);
        push(8'h00, 1'b0, 1'b1);
        start_frame(48'h0123456789AB, 16'h0800);
        send(1501, 1'b0);
        wait_idle(0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tx_ethernet.md
Name: tx_ethernet

Overview:
GMII Ethernet frame transmitter; the transmit-side counterpart of the team's GMII receiver.
- Takes a frame request (destination MAC, length/type) plus a byte-stream payload and serialises it onto GMII.
- Frame order: preamble, SFD, destination MAC, source MAC, length/type, payload, zero padding, optional FCS, then the interframe gap.
- Clocked from RX_CLK; the board forwards RX_CLK as GTX_CLK, so the transmit and receive paths share one clock domain.

Parameters:
- OCT, 8, octet width.
- PRE, 8'b10101010, preamble octet (matches receiver).
- SFD, 8'b10101011, start-frame delimiter octet (matches receiver).
- PRE_LEN, 7, number of preamble octets before SFD.
- MIN_PAYLOAD, 46, minimum payload octets; shorter payloads are zero-padded.
- MAX_PAYLOAD, 1500, maximum payload octets.
- IFG_LEN, 12, idle cycles after each frame.

Ports:
- RX_CLK  input  1  clock; also the GMII transmit clock.
- rst  input  1  reset, synchronous, active-high.
- mac_addr  input  48  local MAC; sent as the source address.
- tx_start  input  1  frame request, single-cycle pulse.
- tx_mac_dst  input  48  destination MAC; latched on accept.
- tx_len_type  input  16  length/type field; latched on accept.
- tx_busy  output  1  high from accept until the end of IFG.
- tx_done  output  1  one-cycle pulse at the end of IFG after a good frame.
- tx_err  output  1  one-cycle pulse when a frame is aborted.
- tx_payload  input  8  payload octet.
- tx_payload_valid  input  1  payload octet valid.
- tx_payload_last  input  1  marks the final payload octet.
- tx_payload_ready  output  1  high only in TX_DATA; combinational from state.
- TXD  output  8  GMII data, registered.
- TX_EN  output  1  GMII enable, registered.
- TX_ER  output  1  GMII error, registered.

Behaviour:
- Reset values:
  - TXD=0, TX_EN=0, TX_ER=0.
  - tx_busy=0, tx_done=0, tx_err=0.
  - State TX_IDLE, counters 0.
- Reset mid-frame: TX_EN drops at the next edge; no tx_done and no tx_err are issued.
- Accept: tx_start=1 in TX_IDLE latches tx_mac_dst and tx_len_type and sets tx_busy. tx_start while busy is ignored.
- Octet timing: GMII outputs are registered, so TXD/TX_EN present the octet chosen by the state one cycle later. The first PRE octet appears the cycle after accept.
- Payload handshake: an octet is consumed when valid&ready; it appears on TXD the following cycle.
- States and transitions:
  - TX_IDLE -> TX_PRE on accept.
  - TX_PRE: PRE_LEN octets of PRE -> TX_SFD.
  - TX_SFD: 1 octet of SFD -> TX_MAC_DST.
  - TX_MAC_DST: 6 octets, MSB octet first, i.e. [47:40] first, matching the receiver's shift order -> TX_MAC_SRC.
  - TX_MAC_SRC: 6 octets of mac_addr, same order -> TX_LEN_TYPE.
  - TX_LEN_TYPE: [15:8] then [7:0] -> TX_DATA.
  - TX_DATA: on a consumed octet with last=1:
    - payload count (including this octet) < MIN_PAYLOAD -> TX_PAD;
    - otherwise -> TX_FCS (or TX_IFG if FCS is compiled out).
  - TX_PAD: emit 0x00 until payload plus pad = MIN_PAYLOAD -> TX_FCS / TX_IFG.
  - TX_FCS: 4 octets -> TX_IFG.
  - TX_IFG: TX_EN=0 for IFG_LEN cycles, then pulse tx_done (if no error), clear tx_busy -> TX_IDLE.
- Underflow: valid=0 in TX_DATA. The next output cycle drives TX_EN=1, TX_ER=1, TXD=0x00; then go to TX_IFG with tx_err pulsed and no tx_done.
- Overflow: a consumed octet that would be octet MAX_PAYLOAD+1 is handled the same as underflow (TX_ER cycle, abort, tx_err).
- Payload counter: 11 bits. Never wraps, because abort triggers at MAX_PAYLOAD+1.
- tx_payload_last=1 with valid=0 is ignored (it counts as underflow).

Optional Feature:
- Macro: TX_FCS_EN.
- Defined:
  - CRC-32 is computed over destination MAC through pad: polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF, final complement.
  - The 4 FCS octets are sent low octet first, in TX_FCS state.
  - CRC updates on every octet emitted from TX_MAC_DST through TX_PAD.
- Undefined: TX_FCS state and CRC logic are absent; the frame ends after payload/pad, i.e. 4 octets shorter.

Test Plan:
- Minimal frame: tx_start with dst=0x112233445566, mac_addr=0xAABBCCDDEEFF, len_type=0x0800, 46 payload octets 0x00..0x2D, valid held high. Required: TX_EN high for 7+1+14+46(+4) cycles; octets AA×7, AB, 11..66, AA..FF, 08, 00, payload; tx_done after 12 idle cycles.
- Padding: 3-octet payload 0x01,0x02,0x03. Required: 43 octets of 0x00 follow the payload; total payload field 46 octets.
- FCS (TX_FCS_EN): a known 60-octet frame from destination MAC to pad gives an FCS matching the software CRC-32 reference. Loopback into the receiver asserts rx_payload_ipv4 and then rx_irq.
- Underflow: drop valid after 10 payload octets. Required: one cycle TX_EN=1/TX_ER=1/TXD=0x00, then TX_EN=0; tx_err pulse; no tx_done.
- Busy/reset: tx_start re-pulsed mid-frame is ignored. rst asserted during TX_MAC_SRC gives TX_EN=0 and tx_busy=0 at the next edge, with no done/err pulse.
- Max length: 1500 octets gives tx_done. A 1501st valid octet gives the TX_ER abort and a tx_err pulse.
